// File: rtl/im_loader.sv
// im_loader: framed byte-stream boot loader that packs words into instruction memory and holds the CPU until verified
module im_loader #(
    parameter int          DEPTH     = 128,
    parameter logic [31:0] ADDR_BASE = 32'h0,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        im_we,
    output logic [31:0] im_addr,
    output logic [31:0] im_wdata,
    output logic        cpu_hold,
    output logic        done,
    output logic        error
);
    localparam logic [2:0] S_SYNC  = 3'd0;
    localparam logic [2:0] S_LEN0  = 3'd1;
    localparam logic [2:0] S_LEN1  = 3'd2;
    localparam logic [2:0] S_DATA  = 3'd3;
    localparam logic [2:0] S_CSUM  = 3'd4;
    localparam logic [2:0] S_WRITE = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;
    localparam logic [2:0] S_ERR   = 3'd7;

    logic [2:0]  r_state;
    logic [15:0] r_len;
    logic [15:0] r_word_idx;
    logic [1:0]  r_byte_cnt;
    logic [7:0]  r_csum;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        w_acc;
    logic [15:0] w_n;
    logic [15:0] w_idx_nx;

    // Byte-accepting states are encoded below WRITE so readiness is a single compare
    assign in_ready = ~rst & (r_state <= S_CSUM);
    assign w_acc    = in_valid & in_ready;
    assign w_n      = {in_data, r_len[7:0]};
    assign w_idx_nx = r_word_idx + 16'd1;
    assign im_we    = (r_state == S_WRITE);
    assign im_addr  = r_addr;
    assign im_wdata = r_wdata;
    assign done     = (r_state == S_DONE);
    assign error    = (r_state == S_ERR);
    assign cpu_hold = ~done;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_SYNC;
            r_len      <= '0;
            r_word_idx <= '0;
            r_byte_cnt <= '0;
            r_csum     <= '0;
            r_addr     <= ADDR_BASE;
            r_wdata    <= '0;
        end else begin
            case (r_state)
                S_SYNC: if (w_acc && in_data == SYNC_BYTE) r_state <= S_LEN0;
                S_LEN0: if (w_acc) begin
                    r_len[7:0] <= in_data;
                    r_state    <= S_LEN1;
                end
                S_LEN1: if (w_acc) begin
                    r_len[15:8] <= in_data;
                    r_state     <= (w_n > 16'(DEPTH)) ? S_ERR : (w_n == 16'd0) ? S_CSUM : S_DATA;
                end
                S_DATA: if (w_acc) begin
                    r_wdata[{r_byte_cnt, 3'b000} +: 8] <= in_data;
                    r_csum     <= r_csum ^ in_data;
                    r_byte_cnt <= r_byte_cnt + 2'd1;
                    if (r_byte_cnt == 2'd3) r_state <= S_WRITE;
                end
                S_WRITE: begin
                    r_word_idx <= w_idx_nx;
                    r_addr     <= r_addr + 32'd4;
                    r_byte_cnt <= '0;
                    r_state    <= (w_idx_nx == r_len) ? S_CSUM : S_DATA;
                end
                S_CSUM: if (w_acc) r_state <= (in_data == r_csum) ? S_DONE : S_ERR;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_im_loader.sv
// tb_im_loader: directed per-cycle vector table plus handshake sequences for the im_loader boot loader
module tb_im_loader;
    logic        clk = 0;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        im_we;
    logic [31:0] im_addr;
    logic [31:0] im_wdata;
    logic        cpu_hold;
    logic        done;
    logic        error;

    im_loader dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata), .cpu_hold(cpu_hold),
        .done(done), .error(error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        r;
        logic        v;
        logic [7:0]  d;
        logic        rdy;
        logic        we;
        logic [31:0] a;
        logic [31:0] w;
        logic        dn;
        logic        er;
    } vec_t;

    vec_t        tv[$];
    logic [31:0] wa[$];
    logic [31:0] wd[$];
    int          n_vec = 0;
    int          n_err = 0;

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s #%0d: got %h, expected %h", nm, idx, act, exp);
        end
    endtask

    function automatic void add(input logic r, input logic v, input logic [7:0] d, input logic rdy,
                                input logic we, input logic [31:0] a, input logic [31:0] w,
                                input logic dn, input logic er);
        tv.push_back('{r, v, d, rdy, we, a, w, dn, er});
    endfunction

    // Samples at the falling edge, logs any write and insists the loader is not ready while writing
    task automatic sample();
        @(negedge clk);
        if (im_we) begin
            wa.push_back(im_addr);
            wd.push_back(im_wdata);
            chk("ready_during_write", wa.size(), {31'b0, in_ready}, 32'd0);
        end
    endtask

    task automatic send(input logic [7:0] b, input bit rnd);
        int  k   = 0;
        bit  acc = 0;
        while (!acc) begin
            in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            in_data  = b;
            sample();
            acc = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (++k > 60) begin
                chk("send_timeout", int'(b), 32'd1, 32'd0);
                acc = 1;
            end
        end
        in_valid = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            in_valid = 0;
            sample();
            @(posedge clk);
            #1;
        end
    endtask

    logic [7:0] f1[] = '{8'hA5, 8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h20, 8'h33};
    logic [7:0] f2[] = '{8'hA5, 8'h02, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11, 8'h55, 8'h66, 8'h77, 8'h88, 8'h88};

    initial begin
        rst = 1; in_valid = 0; in_data = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 0, {31'b0, in_ready}, 32'd0);
        chk("rst_we", 0, {31'b0, im_we}, 32'd0);
        chk("rst_addr", 0, im_addr, 32'd0);
        chk("rst_wdata", 0, im_wdata, 32'd0);
        chk("rst_hold", 0, {31'b0, cpu_hold}, 32'd1);
        chk("rst_flags", 0, {30'b0, done, error}, 32'd0);
        @(posedge clk);
        #1;
        // single-word frame with a byte offered during WRITE that must not be taken
        add(0,1,8'hA5, 1,0,0,0,0,0);
        add(0,1,8'h01, 1,0,0,0,0,0);
        add(0,1,8'h00, 1,0,0,0,0,0);
        add(0,1,8'h13, 1,0,0,0,0,0);
        add(0,1,8'h00, 1,0,0,0,0,0);
        add(0,1,8'h00, 1,0,0,0,0,0);
        add(0,1,8'h20, 1,0,0,0,0,0);
        add(0,1,8'h33, 0,1,0,32'h20000013,0,0);
        add(0,1,8'h33, 1,0,4,0,0,0);
        add(0,1,8'hA5, 0,0,4,0,1,0);
        add(1,0,8'h00, 0,0,4,0,1,0);
        // leading junk, then an empty image
        add(0,1,8'h00, 1,0,0,0,0,0);
        add(0,1,8'hFF, 1,0,0,0,0,0);
        add(0,1,8'hA5, 1,0,0,0,0,0);
        add(0,1,8'h00, 1,0,0,0,0,0);
        add(0,1,8'h00, 1,0,0,0,0,0);
        add(0,1,8'h00, 1,0,0,0,0,0);
        add(0,0,8'h00, 0,0,0,0,1,0);
        add(1,0,8'h00, 0,0,0,0,1,0);
        // two words, bad checksum (good one is 88)
        add(0,1,8'hA5, 1,0,0,0,0,0);
        add(0,1,8'h02, 1,0,0,0,0,0);
        add(0,1,8'h00, 1,0,0,0,0,0);
        add(0,1,8'h44, 1,0,0,0,0,0);
        add(0,1,8'h33, 1,0,0,0,0,0);
        add(0,1,8'h22, 1,0,0,0,0,0);
        add(0,1,8'h11, 1,0,0,0,0,0);
        add(0,0,8'h00, 0,1,0,32'h11223344,0,0);
        add(0,1,8'h55, 1,0,4,0,0,0);
        add(0,1,8'h66, 1,0,4,0,0,0);
        add(0,1,8'h77, 1,0,4,0,0,0);
        add(0,1,8'h88, 1,0,4,0,0,0);
        add(0,0,8'h00, 0,1,4,32'h88776655,0,0);
        add(0,1,8'h89, 1,0,8,0,0,0);
        add(0,1,8'hA5, 0,0,8,0,0,1);
        add(1,0,8'h00, 0,0,8,0,0,1);
        // N=129 rejected right after LEN1
        add(0,1,8'hA5, 1,0,0,0,0,0);
        add(0,1,8'h81, 1,0,0,0,0,0);
        add(0,1,8'h00, 1,0,0,0,0,0);
        add(0,1,8'h13, 0,0,0,0,0,1);
        add(1,0,8'h00, 0,0,0,0,0,1);
        // N=256 rejected through the high length byte
        add(0,1,8'hA5, 1,0,0,0,0,0);
        add(0,1,8'h00, 1,0,0,0,0,0);
        add(0,1,8'h01, 1,0,0,0,0,0);
        add(1,0,8'h00, 0,0,0,0,0,1);
        // N=DEPTH accepted into DATA
        add(0,1,8'hA5, 1,0,0,0,0,0);
        add(0,1,8'h80, 1,0,0,0,0,0);
        add(0,1,8'h00, 1,0,0,0,0,0);
        add(0,0,8'h00, 1,0,0,0,0,0);
        add(1,0,8'h00, 0,0,0,0,0,0);
        foreach (tv[i]) begin
            rst = tv[i].r; in_valid = tv[i].v; in_data = tv[i].d;
            @(negedge clk);
            chk("in_ready", i, {31'b0, in_ready}, {31'b0, tv[i].rdy});
            chk("im_we", i, {31'b0, im_we}, {31'b0, tv[i].we});
            chk("im_addr", i, im_addr, tv[i].a);
            if (tv[i].we) chk("im_wdata", i, im_wdata, tv[i].w);
            chk("done", i, {31'b0, done}, {31'b0, tv[i].dn});
            chk("error", i, {31'b0, error}, {31'b0, tv[i].er});
            chk("cpu_hold", i, {31'b0, cpu_hold}, {31'b0, ~tv[i].dn});
            @(posedge clk);
            #1;
        end
        rst = 0; in_valid = 0;
        // two-word frame with randomly gapped valid
        wa.delete(); wd.delete();
        foreach (f2[i]) send(f2[i], 1);
        idle(3);
        chk("rand_nwrites", 5, wa.size(), 32'd2);
        if (wa.size() == 2) begin
            chk("rand_addr0", 5, wa[0], 32'd0);
            chk("rand_data0", 5, wd[0], 32'h11223344);
            chk("rand_addr1", 5, wa[1], 32'd4);
            chk("rand_data1", 5, wd[1], 32'h88776655);
        end
        chk("rand_done", 5, {30'b0, done, error}, 32'd2);
        // reset two bytes into the data phase, then a full frame
        rst = 1;
        @(posedge clk);
        #1;
        rst = 0;
        for (int i = 0; i < 5; i++) send(f1[i], 0);
        rst = 1;
        @(posedge clk);
        #1;
        rst = 0;
        @(negedge clk);
        chk("midrst_ready", 6, {31'b0, in_ready}, 32'd1);
        chk("midrst_addr", 6, im_addr, 32'd0);
        chk("midrst_hold", 6, {31'b0, cpu_hold}, 32'd1);
        @(posedge clk);
        #1;
        wa.delete(); wd.delete();
        foreach (f1[i]) send(f1[i], 0);
        idle(2);
        chk("reload_nwrites", 6, wa.size(), 32'd1);
        if (wa.size() == 1) begin
            chk("reload_addr", 6, wa[0], 32'd0);
            chk("reload_data", 6, wd[0], 32'h20000013);
        end
        chk("reload_done", 6, {29'b0, done, error, cpu_hold}, 32'd4);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
